// File: rtl/uart_pkg.sv
// Shared UART line encodings and helpers, common to uart_rcv and uart_tnsm.
package uart_pkg;

    localparam int OS_RATE = 16;

    typedef enum logic [1:0] {
        FRAME_5 = 2'b00,
        FRAME_6 = 2'b01,
        FRAME_7 = 2'b10,
        FRAME_8 = 2'b11
    } frame_type_e;

    typedef enum logic [1:0] {
        PARITY_NONE     = 2'b00,
        PARITY_EVEN     = 2'b01,
        PARITY_ODD      = 2'b10,
        PARITY_NONE_ALT = 2'b11
    } parity_type_e;

    // Plain constants rather than an enum keeps the encoding stable for older tooling.
    typedef logic [2:0] uart_rcv_state_e;
    localparam uart_rcv_state_e ST_IDLE   = 3'd0;
    localparam uart_rcv_state_e ST_START  = 3'd1;
    localparam uart_rcv_state_e ST_DATA   = 3'd2;
    localparam uart_rcv_state_e ST_PARITY = 3'd3;
    localparam uart_rcv_state_e ST_STOP1  = 3'd4;
    localparam uart_rcv_state_e ST_STOP2  = 3'd5;

    function automatic logic [3:0] frame_size(input frame_type_e ft);
        return 4'd5 + {2'b00, ft};
    endfunction

    function automatic logic parity_enabled(input parity_type_e pt);
        return ^pt;
    endfunction

    // Bits arrive LSB first into the MSB of a right-shifting register.
    function automatic logic [7:0] align_data(input logic [7:0] sr, input logic [3:0] n);
        return sr >> (4'd8 - n);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, configurable reset value.
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rcv.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery with error flags.
// Optional macro UART_RCV_MAJORITY_EN: 2-of-3 majority vote of samples at os_cnt 7/8/9.
module uart_rcv #(
    parameter int OS_RATE     = uart_pkg::OS_RATE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       active,
    input  logic       rx,
    input  logic [1:0] frame_type,
    input  logic [1:0] parity_type,
    input  logic       stop_type,
    input  logic       rcv_clk_en,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    import uart_pkg::*;

    localparam logic [3:0] LAST_TICK = 4'(OS_RATE - 1);
`ifdef UART_RCV_MAJORITY_EN
    localparam logic [3:0] SAMPLE_TICK = 4'd9;
`else
    localparam logic [3:0] SAMPLE_TICK = 4'd8;
`endif

    logic            rx_s;
    logic            bit_val;
    logic            sample_tick;
    logic            bound_tick;
    logic            armed;
    uart_rcv_state_e state;
    logic [3:0]      os_cnt;
    logic [3:0]      bitcnt;
    logic [7:0]      shift_r;
    logic            par_acc;
    logic            parity_err_r;
    logic            frame_err_r;
    logic            stop_r;
    frame_type_e     frame_r;
    parity_type_e    par_r;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (rx),
        .q      (rx_s)
    );

    assign sample_tick = rcv_clk_en && (os_cnt == SAMPLE_TICK);
    assign bound_tick  = rcv_clk_en && (os_cnt == LAST_TICK);
    assign busy        = (state != ST_IDLE);

`ifdef UART_RCV_MAJORITY_EN
    logic samp7;
    logic samp8;

    // The two earlier votes are captured on their ticks; the third is live rx_s at os_cnt 9.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            samp7 <= 1'b1;
            samp8 <= 1'b1;
        end else if (rcv_clk_en) begin
            if (os_cnt == 4'd7) samp7 <= rx_s;
            if (os_cnt == 4'd8) samp8 <= rx_s;
        end
    end

    assign bit_val = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= ST_IDLE;
            os_cnt       <= 4'd0;
            bitcnt       <= 4'd0;
            armed        <= 1'b0;
            shift_r      <= 8'd0;
            par_acc      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            stop_r       <= 1'b0;
            frame_r      <= FRAME_5;
            par_r        <= PARITY_NONE;
            data         <= 8'd0;
            data_valid   <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rcv_clk_en) os_cnt <= os_cnt + 4'd1;

            case (state)
                ST_IDLE: begin
                    // armed only re-sets on a high line, so a held break cannot retrigger.
                    if (rx_s) armed <= 1'b1;
                    if (rcv_clk_en && active && armed && !rx_s) begin
                        os_cnt  <= 4'd0;
                        armed   <= 1'b0;
                        frame_r <= frame_type_e'(frame_type);
                        par_r   <= parity_type_e'(parity_type);
                        stop_r  <= stop_type;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (sample_tick && bit_val) begin
                        state <= ST_IDLE;
                    end else if (bound_tick) begin
                        bitcnt       <= 4'd0;
                        par_acc      <= 1'b0;
                        parity_err_r <= 1'b0;
                        frame_err_r  <= 1'b0;
                        shift_r      <= 8'd0;
                        state        <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        shift_r <= {bit_val, shift_r[7:1]};
                        par_acc <= par_acc ^ bit_val;
                        bitcnt  <= bitcnt + 4'd1;
                    end else if (bound_tick && (bitcnt == frame_size(frame_r))) begin
                        state <= parity_enabled(par_r) ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    if (sample_tick) begin
                        parity_err_r <= (par_r == PARITY_ODD) ? ~(par_acc ^ bit_val)
                                                              :  (par_acc ^ bit_val);
                    end else if (bound_tick) begin
                        state <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    // A single stop bit completes at its sample so the next start edge is not missed.
                    if (sample_tick) begin
                        frame_err_r <= !bit_val;
                        if (!stop_r) begin
                            data       <= align_data(shift_r, frame_size(frame_r));
                            parity_err <= parity_enabled(par_r) & parity_err_r;
                            frame_err  <= !bit_val;
                            data_valid <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else if (bound_tick && stop_r) begin
                        state <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (sample_tick) begin
                        data       <= align_data(shift_r, frame_size(frame_r));
                        parity_err <= parity_enabled(par_r) & parity_err_r;
                        frame_err  <= frame_err_r | !bit_val;
                        data_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rcv.sv
// Randomized self-checking bench for uart_rcv; frames are built bit by bit from a line-level model.
module tb_uart_rcv;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       active = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] frame_type = 2'b11;
    logic [1:0] parity_type = 2'b00;
    logic       stop_type = 1'b0;
    logic       rcv_clk_en = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int num_compared = 0;
    int num_mismatched = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } result_t;

    result_t got_q[$];

    always #5 clk = ~clk;

    uart_rcv #(
        .OS_RATE     (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .active      (active),
        .rx          (rx),
        .frame_type  (frame_type),
        .parity_type (parity_type),
        .stop_type   (stop_type),
        .rcv_clk_en  (rcv_clk_en),
        .data        (data),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    // Every valid pulse is captured away from the active edge.
    always @(negedge clk) begin
        if (data_valid) got_q.push_back(result_t'{data, parity_err, frame_err});
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One oversample tick; rx has settled through the synchronizer well before the strobe.
    task automatic drive_tick(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        rcv_clk_en = 1'b1;
        @(negedge clk);
        rcv_clk_en = 1'b0;
    endtask

    function automatic result_t model_frame(input logic [1:0] ft, input logic [1:0] pt, input logic st,
                                            input logic [7:0] byte_in, input logic par_flip,
                                            input logic s1_low, input logic s2_low);
        result_t r;
        int n;
        n = 5 + int'(ft);
        r.data = byte_in & 8'((1 << n) - 1);
        r.perr = (pt == 2'b01 || pt == 2'b10) && par_flip;
        r.ferr = s1_low || (st && s2_low);
        return r;
    endfunction

    // Sends one frame at 16 ticks per bit; glitch inverts one tick of data bit 0 (-1 = none).
    task automatic applyStimulus(input logic [1:0] ft, input logic [1:0] pt, input logic st,
                                 input logic [7:0] byte_in, input logic par_flip,
                                 input logic s1_low, input logic s2_low, input int glitch);
        logic bits[$];
        logic [7:0] masked;
        logic pbit;
        logic v;
        int n;
        n = 5 + int'(ft);
        masked = byte_in & 8'((1 << n) - 1);
        frame_type = ft;
        parity_type = pt;
        stop_type = st;
        active = 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(masked[i]);
        if (pt == 2'b01 || pt == 2'b10) begin
            pbit = ^masked;
            if (pt == 2'b10) pbit = ~pbit;
            bits.push_back(pbit ^ par_flip);
        end
        bits.push_back(!s1_low);
        if (st) bits.push_back(!s2_low);
        for (int b = 0; b < bits.size(); b++) begin
            for (int t = 0; t < 16; t++) begin
                v = bits[b];
                if (b == 1 && t == glitch) v = ~v;
                drive_tick(v);
            end
            if (b == 0) begin
                frame_type = 2'($urandom);
                parity_type = 2'($urandom);
                stop_type = 1'($urandom);
                active = 1'($urandom);
            end
        end
        active = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input result_t exp);
        result_t got;
        repeat (4) drive_tick(1'b1);
        checkOutput({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            checkOutput({tag, "_data"}, got.data, exp.data);
            checkOutput({tag, "_perr"}, got.perr, exp.perr);
            checkOutput({tag, "_ferr"}, got.ferr, exp.ferr);
        end
        checkOutput({tag, "_busy"}, busy, 1'b0);
        got_q.delete();
    endtask

    initial begin
        result_t r;
        logic [1:0] ft;
        logic [1:0] pt;
        logic st;
        logic [7:0] b;
        logic pf;
        logic s1;
        logic s2;

        repeat (3) @(negedge clk);
        checkOutput("rst_data", data, 8'h00);
        checkOutput("rst_valid", data_valid, 1'b0);
        checkOutput("rst_perr", parity_err, 1'b0);
        checkOutput("rst_ferr", frame_err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        arst_n = 1'b1;
        active = 1'b1;
        repeat (4) drive_tick(1'b1);

        applyStimulus(2'b11, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
        expect_frame("8n1_a5", model_frame(2'b11, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));

        applyStimulus(2'b10, 2'b01, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0, -1);
        expect_frame("7e1_good", result_t'{8'h35, 1'b0, 1'b0});
        applyStimulus(2'b10, 2'b01, 1'b0, 8'h35, 1'b1, 1'b0, 1'b0, -1);
        expect_frame("7e1_bad", result_t'{8'h35, 1'b1, 1'b0});

        applyStimulus(2'b00, 2'b10, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b1, -1);
        expect_frame("5o2_stop2", result_t'{8'h1F, 1'b0, 1'b1});
        applyStimulus(2'b00, 2'b10, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, -1);
        expect_frame("5o2_next", result_t'{8'h0A, 1'b0, 1'b0});

        // Short start pulse must be rejected at the start-bit sample.
        frame_type = 2'b11; parity_type = 2'b00; stop_type = 1'b0;
        repeat (2) drive_tick(1'b0);
        checkOutput("glitch_busy_hi", busy, 1'b1);
        repeat (2) drive_tick(1'b0);
        repeat (8) drive_tick(1'b1);
        checkOutput("glitch_busy_lo", busy, 1'b0);
        repeat (20) drive_tick(1'b1);
        checkOutput("glitch_none", got_q.size(), 0);

        repeat (200) drive_tick(1'b0);
        expect_frame("break", result_t'{8'h00, 1'b0, 1'b1});
        applyStimulus(2'b11, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
        expect_frame("after_break", result_t'{8'h3C, 1'b0, 1'b0});

        applyStimulus(2'b11, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 9);
`ifdef UART_RCV_MAJORITY_EN
        expect_frame("mid_glitch", result_t'{8'hFF, 1'b0, 1'b0});
`else
        expect_frame("mid_glitch", result_t'{8'hFE, 1'b0, 1'b0});
`endif

        frame_type = 2'b11; parity_type = 2'b00; stop_type = 1'b0;
        for (int i = 0; i < 40; i++) drive_tick(i < 16 ? 1'b0 : 1'b1);
        checkOutput("midrst_busy_pre", busy, 1'b1);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_data", data, 8'h00);
        checkOutput("midrst_valid", data_valid, 1'b0);
        checkOutput("midrst_ferr", frame_err, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (200) drive_tick(1'b1);
        checkOutput("midrst_none", got_q.size(), 0);
        got_q.delete();

        for (int k = 0; k < 25; k++) begin
            ft = 2'($urandom_range(0, 3));
            pt = 2'($urandom_range(0, 3));
            st = 1'($urandom_range(0, 1));
            b  = 8'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 5) == 0);
            s2 = ($urandom_range(0, 5) == 0);
            applyStimulus(ft, pt, st, b, pf, s1, s2, -1);
            r = model_frame(ft, pt, st, b, pf, s1, s2);
            expect_frame($sformatf("rand%0d", k), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
